inv_arbiter: RTL

INV_ARBITER -- requirements
Module: inv_arbiter

---
 rtl/ecc_inv_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/inv_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/ecc_inv_pkg.sv
// Shared definitions for the invMod arbiter.
//   state_t       - arbiter FSM states; FLUSH is only entered when the
//                   INV_ARB_TIMEOUT_EN build option is defined.
//   DEFAULT_WIDTH - default operand/result width.
package ecc_inv_pkg;

  localparam int unsigned DEFAULT_WIDTH = 256;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    FLUSH
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: scans requesters starting at ptr, wrapping modulo NUM_REQ,
// and returns the first requesting index.
// Ports:
//   req     in  NUM_REQ  request vector
//   ptr     in  PTR_W    highest-priority index for this pick
//   grant   out NUM_REQ  one-hot grant (all zero when no request)
//   winner  out PTR_W    index of the granted requester
//   any_req out 1        at least one request present
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned PTR_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   winner,
  output logic               any_req
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    grant   = '0;
    winner  = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((32'(ptr) + i) % NUM_REQ);
      if (!any_req && req[idx]) begin
        any_req    = 1'b1;
        winner     = idx;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/inv_arbiter.sv
// Shares one modular-inverse engine between NUM_REQ requesters. One operation
// is in flight at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE, with the
// winner chosen round-robin starting from rr_ptr.
// Build option: INV_ARB_TIMEOUT_EN adds a WAIT watchdog; after TIMEOUT WAIT
// cycles the engine is reset for 2 cycles (FLUSH) and the owner receives an
// error response (rsp_err=1, rsp_data=0).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       per-requester request / accept pulse
//   req_opA/req_opM           flattened operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_data/rsp_err one-hot result pulse, shared result bus, error flag
//   inv_opA/inv_opM/inv_in_valid   engine operands and start pulse
//   inv_out_data/inv_out_valid     engine result
//   inv_rst_n                 engine active-low reset
//   busy                      high whenever the FSM is not IDLE
module inv_arbiter
  import ecc_inv_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_opA,
  input  logic [NUM_REQ*WIDTH-1:0] req_opM,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     rsp_err,
  output logic [WIDTH-1:0]         inv_opA,
  output logic [WIDTH-1:0]         inv_opM,
  output logic                     inv_in_valid,
  input  logic [WIDTH-1:0]         inv_out_data,
  input  logic                     inv_out_valid,
  output logic                     inv_rst_n,
  output logic                     busy
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_param_check
    $error("inv_arbiter: NUM_REQ must be 2..8 and TIMEOUT at least 1");
  end

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   owner;
  logic [PTR_W-1:0]   winner;
  logic [NUM_REQ-1:0] grant;
  logic               any_req;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .grant  (grant),
    .winner (winner),
    .any_req(any_req)
  );

  // Accept is combinational so the handshake completes in the IDLE cycle;
  // gated by rst so nothing is accepted while in reset.
  assign req_ready = (state == IDLE && !rst) ? grant : '0;
  assign busy      = (state != IDLE);

`ifdef INV_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  // Counts WAIT cycles, then reused to time the 2-cycle FLUSH.
  logic [CNT_W-1:0] wait_cnt;
`else
  assign rsp_err   = 1'b0;
  assign inv_rst_n = ~rst;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      rsp_valid    <= '0;
      rsp_data     <= '0;
      inv_in_valid <= 1'b0;
      inv_opA      <= '0;
      inv_opM      <= '0;
`ifdef INV_ARB_TIMEOUT_EN
      rsp_err      <= 1'b0;
      wait_cnt     <= '0;
      inv_rst_n    <= 1'b0;
`endif
    end else begin
      inv_in_valid <= 1'b0;
      rsp_valid    <= '0;
`ifdef INV_ARB_TIMEOUT_EN
      rsp_err      <= 1'b0;
      inv_rst_n    <= 1'b1;
`endif
      case (state)
        IDLE: begin
          if (any_req) begin
            owner        <= winner;
            inv_opA      <= req_opA[winner*WIDTH +: WIDTH];
            inv_opM      <= req_opM[winner*WIDTH +: WIDTH];
            // Registered here so the start pulse coincides with ISSUE.
            inv_in_valid <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
`ifdef INV_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          if (inv_out_valid) begin
            rsp_data  <= inv_out_data;
            rsp_valid <= NUM_REQ'(1) << owner;
            state     <= RESP;
          end
`ifdef INV_ARB_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            wait_cnt  <= '0;
            inv_rst_n <= 1'b0;
            state     <= FLUSH;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
`ifdef INV_ARB_TIMEOUT_EN
        FLUSH: begin
          if (wait_cnt == CNT_W'(1)) begin
            rsp_valid <= NUM_REQ'(1) << owner;
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
            state     <= RESP;
          end else begin
            wait_cnt  <= wait_cnt + 1'b1;
            inv_rst_n <= 1'b0;
          end
        end
`endif
        RESP: begin
          rr_ptr <= (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
